data_memory: RTL
================

Name: data_memory

Overview:
- Byte-addressable data memory for the single-cycle RV32I core; it is the responder on the DMWr/DMCtrl/Address/DataWr interface driven by the control unit and ALU.
- Loads are combinational, so they complete in the same cycle. Stores commit at the clock edge with byte, half or word lane enables selected by DMCtrl (Funct3).
- After reset, an internal sweep clears the array before `Ready` rises.
- Misaligned or illegal stores are recorded in sticky fault registers.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, at least 2.
- ADDR_W, 32, width of Address.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Address  in  ADDR_W  byte address from the ALU
- DataWr  in  32  store data (rs2)
- DMWr  in  1  store request
- DMCtrl  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal
- DataRd  out  32  load result, sign- or zero-extended
- Ready  out  1  init sweep complete
- Fault  out  1  sticky: a misaligned or illegal store was attempted
- FaultAddr  out  ADDR_W  Address of the first faulting store
- StoreCount  out  32  count of committed stores; wraps

Behaviour:
- Interface rules: one clock; reset is synchronous and active-high.
- Values while rst is sampled high: state=INIT, InitCnt=0, Ready=0, Fault=0, FaultAddr=0, StoreCount=0.
- Indexing: word index = Address[IW+1:2], where IW=$clog2(DEPTH_WORDS). Higher address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS.
- Alignment: H/HU is aligned iff Address[0]=0. W is aligned iff Address[1:0]=00. B/BU is always aligned.
- FSM INIT:
  - Each cycle, write 32'h0 to word InitCnt, then InitCnt++.
  - When InitCnt==DEPTH_WORDS-1, write that word and move to READY next cycle.
  - Ready rises exactly DEPTH_WORDS cycles after the first cycle with rst low.
  - In INIT: DataRd=0, DMWr ignored, no fault capture, StoreCount held.
- FSM READY: stays until rst. rst asserted mid-operation restarts INIT and the full sweep.
- Load path (READY, combinational, zero latency):
  - B: sign-extend the byte at lane Address[1:0].
  - BU: zero-extend the byte at lane Address[1:0].
  - H: sign-extend the half at Address[1].
  - HU: zero-extend the half at Address[1].
  - W: the full word.
  - Misaligned or illegal DMCtrl: DataRd=0.
- Store commit (READY, at the edge with DMWr=1, aligned, legal DMCtrl):
  - SB writes DataWr[7:0] to the addressed lane only.
  - SH writes DataWr[15:0] to lanes {1,0} or {3,2}.
  - SW writes all lanes.
  - Lanes that are not written keep their value.
  - StoreCount++ (32'hFFFFFFFF wraps to 0).
- Store with DMCtrl of 100/101 (a load-only encoding): treated as illegal.
- Faulting store (READY, DMWr=1, misaligned or illegal):
  - No array write; StoreCount held.
  - Fault set to 1.
  - FaultAddr loads Address only if Fault was 0 (first fault wins).
  - Only rst clears Fault and FaultAddr.
- Loads never fault; the core presents arbitrary addresses on non-load instructions.
- Read-during-write, same word: DataRd shows the old data for the rest of that cycle and the new data from the next cycle.
- DMWr=0: no array change.

Decomposition:
- Package dm_pkg holds:
  - typedef enum logic [2:0] dm_ctrl_e: DM_B=000, DM_H=001, DM_W=010, DM_BU=100, DM_HU=101.
  - typedef enum logic {DM_INIT, DM_READY} dm_state_e.
  - Function dm_aligned(ctrl, addr_lo).
- Sub-module dm_load_extract (combinational) takes the raw word, Address[1:0] and DMCtrl, and produces the extended DataRd. The store lane-enable generation stays inline.

Test Plan:
- Reset, DEPTH_WORDS=256: hold rst for 3 cycles, then release. Ready=0 for 256 cycles, then 1. A W read at any address returns 0. DMWr=1 during INIT leaves StoreCount=0.
- SW 0x8899AABB @0x10, then read back:
  - LW @0x10 = 0x8899AABB
  - LB @0x11 = 0xFFFFFFAA
  - LBU @0x11 = 0x000000AA
  - LH @0x12 = 0xFFFF8899
  - LHU @0x12 = 0x00008899
  - StoreCount=1
- Starting from word 0x8899AABB @0x10, apply SB 0x12 @0x13, then SH 0x3456 @0x10. LW @0x10 = 0x12993456; StoreCount=3.
- SW @0x22: no write, Fault=1, FaultAddr=0x22. Then SH @0x31: FaultAddr stays 0x22. A LW @0x22 returns 0 and does not change the fault registers.
- Store with DMCtrl=011 @0x40: memory unchanged and Fault=1. SW @0x400 (DEPTH_WORDS=256) aliases to @0x0.
- Read-during-write at word 0x50 (old value 0xDEADBEEF), in the same cycle as SW 0x11111111: DataRd = 0xDEADBEEF that cycle and 0x11111111 the next. rst mid-run: Ready drops, the sweep reruns, and LW @0x50 returns 0 afterwards.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and helpers for the RV32I data memory.
package dm_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    typedef enum logic {
        DM_INIT  = 1'b0,
        DM_READY = 1'b1
    } dm_state_e;

    // Natural alignment of an access; unknown encodings report misaligned.
    function automatic logic dm_aligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (ctrl)
            DM_B, DM_BU: ok = 1'b1;
            DM_H, DM_HU: ok = ~addr_lo[0];
            DM_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Core-to-data-memory bus: ALU address, store data and control in, load data and status out.
interface data_memory_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataWr;
    logic              DMWr;
    logic [2:0]        DMCtrl;
    logic [31:0]       DataRd;
    logic              Ready;
    logic              Fault;
    logic [ADDR_W-1:0] FaultAddr;
    logic [31:0]       StoreCount;

    modport master (
        output Address, DataWr, DMWr, DMCtrl,
        input  DataRd, Ready, Fault, FaultAddr, StoreCount
    );

    modport slave (
        input  Address, DataWr, DMWr, DMCtrl,
        output DataRd, Ready, Fault, FaultAddr, StoreCount
    );
endinterface

// File: rtl/dm_load_extract.sv
// Selects and sign/zero-extends the load lane from a raw memory word.
module dm_load_extract
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_ctrl,
    output logic [31:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        o_data_c = '0;
        if (dm_aligned(i_ctrl, i_addr_lo)) begin
            case (i_ctrl)
                DM_B:    o_data_c = {{24{w_byte[7]}}, w_byte};
                DM_BU:   o_data_c = {24'h0, w_byte};
                DM_H:    o_data_c = {{16{w_half[15]}}, w_half};
                DM_HU:   o_data_c = {16'h0, w_half};
                DM_W:    o_data_c = i_word;
                default: o_data_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory: combinational loads, lane-masked stores,
// post-reset clearing sweep and sticky store-fault capture.
module data_memory
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);

    localparam int unsigned IW = $clog2(DEPTH_WORDS);

    dm_state_e         r_state;
    logic [IW-1:0]     r_init_cnt;
    logic              r_fault;
    logic [ADDR_W-1:0] r_fault_addr;
    logic [31:0]       r_store_cnt;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic [IW-1:0] w_idx;
    logic [1:0]    w_lo;
    logic          w_ready;
    logic          w_legal;
    logic          w_store;
    logic          w_fault;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ext;

    assign w_idx   = bus.Address[IW+1:2];
    assign w_lo    = bus.Address[1:0];
    assign w_ready = (r_state == DM_READY);
    // Load-only encodings (BU/HU) are not valid store types.
    assign w_legal = ((bus.DMCtrl == DM_B) || (bus.DMCtrl == DM_H) || (bus.DMCtrl == DM_W))
                     && dm_aligned(bus.DMCtrl, w_lo);
    assign w_store = w_ready & bus.DMWr & w_legal;
    assign w_fault = w_ready & bus.DMWr & ~w_legal;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = '0;
        case (bus.DMCtrl)
            DM_B: begin
                w_be    = 4'b0001 << w_lo;
                w_wdata = {4{bus.DataWr[7:0]}};
            end
            DM_H: begin
                w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.DataWr[15:0]}};
            end
            DM_W: begin
                w_be    = 4'b1111;
                w_wdata = bus.DataWr;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DM_INIT;
            r_init_cnt   <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_store_cnt  <= '0;
        end else begin
            case (r_state)
                DM_INIT: begin
                    r_init_cnt <= r_init_cnt + IW'(1);
                    if (r_init_cnt == IW'(DEPTH_WORDS - 1)) begin
                        r_state <= DM_READY;
                    end
                end
                DM_READY: begin
                    if (w_store) begin
                        r_store_cnt <= r_store_cnt + 32'd1;
                    end
                    if (w_fault) begin
                        r_fault <= 1'b1;
                        if (!r_fault) begin
                            r_fault_addr <= bus.Address;
                        end
                    end
                end
                default: r_state <= DM_INIT;
            endcase
        end
    end

    // Array port: sweep clears one word per cycle, then lane-masked stores.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == DM_INIT) begin
                r_mem[r_init_cnt] <= '0;
            end else if (w_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    dm_load_extract u_load_extract (
        .i_word    (r_mem[w_idx]),
        .i_addr_lo (w_lo),
        .i_ctrl    (bus.DMCtrl),
        .o_data_c  (w_ext)
    );

    assign bus.DataRd     = w_ready ? w_ext : 32'h0;
    assign bus.Ready      = w_ready;
    assign bus.Fault      = r_fault;
    assign bus.FaultAddr  = r_fault_addr;
    assign bus.StoreCount = r_store_cnt;

endmodule
